// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial addition controller.
package serial_add_pkg;

    // Operand/result width used when the instantiating code does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit counter width: enough to count 0..w-1, never less than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bus of the serial adder.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // The requester drives start and the operands and watches the result.
    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    // The controller consumes the request and owns the result.
    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/bit_slice_adder.sv
// Combinational 1-bit full adder built from two half-adder stages.
module bit_slice_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic c
);

    logic hs_sum;
    logic hs_carry;
    logic fs_carry;

    // First half adder combines the two operand bits.
    assign hs_sum   = x ^ y;
    assign hs_carry = x & y;

    // Second half adder folds in the incoming carry.
    assign s        = hs_sum ^ cin;
    assign fs_carry = hs_sum & cin;

    // A carry out is produced by either stage, never both at once.
    assign c        = hs_carry | fs_carry;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice walks two WIDTH-bit
// operands LSB first, one bit per clock, and presents a registered result.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt;

    logic             slice_s;
    logic             slice_c;

    // The single adder slice always looks at the current LSBs and carry.
    bit_slice_adder u_slice (
        .x   (shift_a[0]),
        .y   (shift_b[0]),
        .cin (carry),
        .s   (slice_s),
        .c   (slice_c)
    );

    // Sequencer: accepts a request, steps the slice WIDTH times, pulses done.
    // NOTE: every register here is assigned with <= so all of them update
    // together from pre-edge values; a blocking = would let later statements
    // see already-shifted operands and corrupt the bit being added.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shift registers are plain flops, not a memory, so they are
        // cleared with everything else and an aborted operation leaves nothing behind.
        if (!rst_n) begin
            state   <= IDLE;
            shift_a <= '0;
            shift_b <= '0;
            result  <= '0;
            carry   <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_a <= bus.a;
                        shift_b <= bus.b;
                        carry   <= 1'b0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    // Sum bits enter at the top and drift down to their final place.
                    result  <= {slice_s, result[WIDTH-1:1]};
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    carry   <= slice_c;
                    if (cnt == LAST) begin
                        // Last bit: its carry is the carry out of the whole word.
                        cout_q <= slice_c;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    // Start is not sampled here; a request now is simply dropped.
                    done_q <= 1'b0;
                    state  <= IDLE;
                end

                // NOTE: the default arm catches the unused encoding 2'b11 and
                // steers it home instead of letting the FSM lock up.
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from flops; no input reaches them combinationally.
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = result;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 2, 8 and 32.
// Expected results come from plain integer addition of the operands.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(2))  bus2  ();
    serial_add_ctrl_if #(.WIDTH(8))  bus8  ();
    serial_add_ctrl_if #(.WIDTH(32)) bus32 ();

    serial_add_ctrl #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
    serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int widths [3] = '{2, 8, 32};

    logic [31:0] obs_sum  [3];
    logic        obs_busy [3];
    logic        obs_done [3];
    logic        obs_cout [3];

    assign obs_sum[0]  = {30'd0, bus2.sum};
    assign obs_sum[1]  = {24'd0, bus8.sum};
    assign obs_sum[2]  = bus32.sum;
    assign obs_busy[0] = bus2.busy;
    assign obs_busy[1] = bus8.busy;
    assign obs_busy[2] = bus32.busy;
    assign obs_done[0] = bus2.done;
    assign obs_done[1] = bus8.done;
    assign obs_done[2] = bus32.done;
    assign obs_cout[0] = bus2.cout;
    assign obs_cout[1] = bus8.cout;
    assign obs_cout[2] = bus32.cout;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int idx, input logic st, input logic [31:0] a, input logic [31:0] b);
        case (idx)
            0: begin bus2.start  = st; bus2.a  = a[1:0]; bus2.b  = b[1:0]; end
            1: begin bus8.start  = st; bus8.a  = a[7:0]; bus8.b  = b[7:0]; end
            default: begin bus32.start = st; bus32.a = a; bus32.b = b; end
        endcase
    endtask

    task automatic check_all_zero(input int idx, input string tag);
        check({tag, "_busy"}, 64'(obs_busy[idx]), 64'd0);
        check({tag, "_done"}, 64'(obs_done[idx]), 64'd0);
        check({tag, "_sum"},  64'(obs_sum[idx]),  64'd0);
        check({tag, "_cout"}, 64'(obs_cout[idx]), 64'd0);
    endtask

    // One addition, issued at the current negedge. Returns at the first negedge
    // where a new start would be accepted. With noise set, start is held high
    // with junk operands throughout RUN and DONE; none of it may be accepted.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, input string tag);
        int          w;
        int          busy_n;
        int          done_n;
        int          done_k;
        logic [63:0] mask;
        logic [63:0] total;
        logic [63:0] got_sum;
        logic [63:0] got_cout;
        w        = widths[idx];
        busy_n   = 0;
        done_n   = 0;
        done_k   = 0;
        got_sum  = '0;
        got_cout = '0;
        mask     = (64'd1 << w) - 64'd1;
        total    = (64'(a) & mask) + (64'(b) & mask);
        drive(idx, 1'b1, a, b);
        for (int k = 1; k <= w + 2; k++) begin
            @(negedge clk);
            if (obs_busy[idx]) busy_n++;
            if (obs_done[idx]) begin
                done_n++;
                done_k   = k;
                got_sum  = 64'(obs_sum[idx]);
                got_cout = 64'(obs_cout[idx]);
            end
            if (k <= w + 1 && noise) drive(idx, 1'b1, $urandom, $urandom);
            else                     drive(idx, 1'b0, $urandom, $urandom);
        end
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(w));
        check({tag, "_done_pulses"}, 64'(done_n), 64'd1);
        check({tag, "_done_edge"},   64'(done_k), 64'(w + 1));
        check({tag, "_sum_cout"},    (got_cout << w) | got_sum, total);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 32'd0, 32'd0);
        drive(2, 1'b0, 32'd0, 32'd0);

        // Reset state of every instance.
        #12;
        for (int i = 0; i < 3; i++) check_all_zero(i, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_all_zero(i, "post_reset");

        // 0x0F + 0x01.
        run_op(1, 32'h0F, 32'h01, 1'b0, "t_0f_01");
        check("t_0f_01_sum",  64'(obs_sum[1]),  64'h10);
        check("t_0f_01_cout", 64'(obs_cout[1]), 64'd0);

        // 0xFF + 0x01 then 0xFF + 0xFF at the earliest accepting edge.
        run_op(1, 32'hFF, 32'h01, 1'b0, "t_ff_01");
        check("t_ff_01_sum",  64'(obs_sum[1]),  64'h00);
        check("t_ff_01_cout", 64'(obs_cout[1]), 64'd1);
        run_op(1, 32'hFF, 32'hFF, 1'b0, "t_ff_ff");
        check("t_ff_ff_sum",  64'(obs_sum[1]),  64'hFE);
        check("t_ff_ff_cout", 64'(obs_cout[1]), 64'd1);

        // Start re-pulsed during RUN and DONE is ignored.
        @(negedge clk);
        run_op(1, 32'h3C, 32'h5A, 1'b1, "t_3c_5a");
        check("t_3c_5a_sum",  64'(obs_sum[1]),  64'h96);
        check("t_3c_5a_cout", 64'(obs_cout[1]), 64'd0);
        @(negedge clk);
        check("t_3c_5a_no_rerun", 64'(obs_busy[1]), 64'd0);

        // Reset in the fourth cycle of RUN aborts the operation.
        drive(1, 1'b1, 32'hFF, 32'hFF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive(1, 1'b0, $urandom, $urandom);
        end
        check("abort_busy_before", 64'(obs_busy[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero(1, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int stray_done;
            int stray_busy;
            stray_done = 0;
            stray_busy = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (obs_done[1]) stray_done++;
                if (obs_busy[1]) stray_busy++;
            end
            check("abort_no_done", 64'(stray_done), 64'd0);
            check("abort_no_busy", 64'(stray_busy), 64'd0);
        end
        run_op(1, 32'h01, 32'h02, 1'b0, "t_01_02");
        check("t_01_02_sum",  64'(obs_sum[1]),  64'h03);
        check("t_01_02_cout", 64'(obs_cout[1]), 64'd0);

        // Result holds while the operands wander and start stays low.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1, 1'b0, $urandom, $urandom);
            check("hold_sum",  64'(obs_sum[1]),  64'h03);
            check("hold_cout", 64'(obs_cout[1]), 64'd0);
            check("hold_busy", 64'(obs_busy[1]), 64'd0);
        end

        // Random operand pairs at every width.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 1000; n++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                run_op(i, $urandom, $urandom, ($urandom_range(0, 9) == 0),
                       $sformatf("rnd_w%0d", widths[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
